// File: rtl/sequencer_pkg.sv
// sequencer_pkg: shared FSM state type, default pattern constants and bit-count width helper.
package sequencer_pkg;

    typedef enum logic {IDLE, SHIFT} state_t;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_PAT_W = 8;
    localparam logic [DEF_PAT_W-1:0] DEF_PATTERN = 8'b0101_0111;

    function automatic int cnt_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int BIT_CNT_W = cnt_w(DEF_DATA_W);

endpackage

// File: rtl/seq_bit_detector.sv
// seq_bit_detector: serial bit history with saturating fill count and registered match pulse.
module seq_bit_detector
    import sequencer_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN
) (
    input  logic clk,
    input  logic reset,
    input  logic bit_en,
    input  logic bit_in,
    output logic match
);

    localparam int VW = $clog2(PAT_W + 1);

    logic [PAT_W-1:0] history_d, history_q;
    logic [VW-1:0] valid_d, valid_q;
    logic match_d, match_q;

    // shift the new bit in and flag a match once the window is fully populated
    always_comb begin
        history_d = bit_en ? PAT_W'({history_q, bit_in}) : history_q;
        valid_d = (bit_en && valid_q != VW'(PAT_W)) ? valid_q + 1'b1 : valid_q;
        match_d = bit_en && history_d == PATTERN && valid_d == VW'(PAT_W);
    end

    // state registers, cleared by reset so a dropped partial byte cannot match later
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            history_q <= '0;
            valid_q <= '0;
            match_q <= 1'b0;
        end else begin
            history_q <= history_d;
            valid_q <= valid_d;
            match_q <= match_d;
        end
    end

    assign match = match_q;

endmodule

// File: rtl/sequencer.sv
// sequencer: byte handshake + MSB-first serializer feeding a bit-level pattern detector.
// Optional match_count output enabled by SEQUENCER_MATCH_CNT_EN.
module sequencer
    import sequencer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int PAT_W = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data,
    input  logic              sent,
    output logic              ready,
    output logic              match
`ifdef SEQUENCER_MATCH_CNT_EN
    ,
    output logic [7:0]        match_count
`endif
);

    localparam int CW = cnt_w(DATA_W);

    state_t state_d, state_q;
    logic ready_d, ready_q;
    logic [DATA_W-1:0] sreg_d, sreg_q;
    logic [CW-1:0] cnt_d, cnt_q;
    logic accept, shifting, last;

    // accept a byte in IDLE, then emit one bit per cycle until the byte is exhausted
    always_comb begin
        accept = sent && ready_q;
        shifting = state_q == SHIFT;
        last = shifting && cnt_q == CW'(DATA_W - 1);
        state_d = accept ? SHIFT : last ? IDLE : state_q;
        ready_d = accept ? 1'b0 : last ? 1'b1 : ready_q;
        sreg_d = accept ? data : shifting ? sreg_q << 1 : sreg_q;
        cnt_d = (accept || last) ? '0 : shifting ? cnt_q + 1'b1 : cnt_q;
    end

    // handshake/serializer state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            sreg_q <= '0;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            sreg_q <= sreg_d;
            cnt_q <= cnt_d;
        end
    end

    assign ready = ready_q;

    seq_bit_detector #(.PAT_W(PAT_W), .PATTERN(PATTERN)) u_det (
        .clk(clk),
        .reset(reset),
        .bit_en(shifting),
        .bit_in(sreg_q[DATA_W-1]),
        .match(match)
    );

`ifdef SEQUENCER_MATCH_CNT_EN
    logic [7:0] match_cnt_d, match_cnt_q;

    // saturating count of match pulses since reset
    always_comb match_cnt_d = (match && match_cnt_q != 8'hFF) ? match_cnt_q + 8'd1 : match_cnt_q;

    // match counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) match_cnt_q <= '0;
        else match_cnt_q <= match_cnt_d;
    end

    assign match_count = match_cnt_q;
`endif

endmodule

// File: tb/tb_sequencer.sv
// tb_sequencer: table-driven and scripted checks of the sequencer against a bit-stream model.
module tb_sequencer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sent = 1'b0;
    logic [7:0] data = 8'h00;
    logic ready, match;
`ifdef SEQUENCER_MATCH_CNT_EN
    logic [7:0] match_count;
`endif

    sequencer dut (
        .clk(clk),
        .reset(reset),
        .data(data),
        .sent(sent),
        .ready(ready),
        .match(match)
`ifdef SEQUENCER_MATCH_CNT_EN
        ,
        .match_count(match_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    bit exp_q[$];
    logic [31:0] hist = '0;
    int valid = 0;
    int model_pulses = 0;
    int seen_pulses = 0;

    typedef struct {
        logic [7:0] d;
        int pulses;
        int first;
        bit hold;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist = '0;
        valid = 0;
        exp_q.delete();
        model_pulses = 0;
        seen_pulses = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        bit e;
        for (int i = 7; i >= 0; i--) begin
            hist = {hist[30:0], b[i]};
            if (valid < 8) valid++;
            e = (valid >= 8) && (hist[7:0] == 8'b0101_0111);
            exp_q.push_back(e);
            if (e) model_pulses++;
        end
    endtask

    task automatic check_count();
`ifdef SEQUENCER_MATCH_CNT_EN
        chk("match_count", match_count, (model_pulses > 255) ? 255 : model_pulses);
`endif
    endtask

    // called at a negedge; returns at the negedge after the last bit edge
    task automatic send_byte(input logic [7:0] b, input bit hold,
                             output int pulses, output int first_bit, output int acc_cyc);
        int n;
        bit e;
        data = b;
        sent = 1'b1;
        n = 0;
        while (!ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_accept", ready, 1);
        model_byte(b);
        @(posedge clk);
        @(negedge clk);
        acc_cyc = cyc;
        if (!hold) sent = 1'b0;
        data = 8'($urandom);
        chk("ready_after_accept", ready, 0);
        chk("match_after_accept", match, 0);
        pulses = 0;
        first_bit = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (exp_q.size() == 0) begin
                chk("scoreboard_empty", 1, 0);
                e = 1'b0;
            end else begin
                e = exp_q.pop_front();
            end
            chk("match_bit", match, e);
            chk("ready_bit", ready, (k == 8) ? 1 : 0);
            if (match) begin
                pulses++;
                seen_pulses++;
                if (first_bit == 0) first_bit = k;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int p, f, acc, prev_acc;
        tbl[0] = '{d: 8'h57, pulses: 1, first: 8, hold: 1'b0};
        tbl[1] = '{d: 8'hFF, pulses: 0, first: 0, hold: 1'b1};
        tbl[2] = '{d: 8'h00, pulses: 0, first: 0, hold: 1'b0};
        tbl[3] = '{d: 8'hA5, pulses: 0, first: 0, hold: 1'b0};
        tbl[4] = '{d: 8'h7C, pulses: 1, first: 4, hold: 1'b0};
        tbl[5] = '{d: 8'h57, pulses: 1, first: 8, hold: 1'b0};

        // reset held, then released
        repeat (3) @(negedge clk);
        chk("reset_ready", ready, 1);
        chk("reset_match", match, 0);
        check_count();
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        chk("post_reset_ready", ready, 1);
        chk("post_reset_match", match, 0);
        check_count();

        // table-driven bytes
        prev_acc = 0;
        for (int i = 0; i < 6; i++) begin
            send_byte(tbl[i].d, tbl[i].hold, p, f, acc);
            chk("tbl_pulses", p, tbl[i].pulses);
            chk("tbl_first_bit", f, tbl[i].first);
            if (i > 0 && tbl[i-1].hold) chk("accept_spacing", acc - prev_acc, 9);
            prev_acc = acc;
            if (!tbl[i].hold) begin
                @(negedge clk);
                chk("idle_match", match, 0);
                chk("idle_ready", ready, 1);
                check_count();
            end
        end

        // reset four bits into a byte, then resend it
        data = 8'h57;
        sent = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sent = 1'b0;
        chk("abort_ready_low", ready, 0);
        repeat (4) begin
            @(negedge clk);
            chk("abort_match", match, 0);
        end
        reset = 1'b1;
        #1;
        chk("async_reset_ready", ready, 1);
        chk("async_reset_match", match, 0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        check_count();
        repeat (3) begin
            @(negedge clk);
            chk("after_abort_match", match, 0);
        end
        send_byte(8'h57, 1'b0, p, f, acc);
        chk("resend_pulses", p, 1);
        chk("resend_first_bit", f, 8);
        @(negedge clk);
        check_count();

        // random stream ending with the pattern byte, sent held throughout
        for (int i = 0; i < 20; i++) begin
            send_byte(8'($urandom), 1'b1, p, f, acc);
            if (i > 0) chk("rand_spacing", acc - prev_acc, 9);
            prev_acc = acc;
        end
        send_byte(8'h57, 1'b0, p, f, acc);
        chk("rand_last_pulse", f != 0, 1);
        @(negedge clk);
        chk("rand_pulse_total", seen_pulses, model_pulses);
        check_count();
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
